// File: rtl/hilo_pkg.sv
// hilo_pkg: shared op encodings, FSM states and accumulator width for the HI/LO unit
package hilo_pkg;
    localparam int ACC_W = 64;
    typedef enum logic [2:0] {
        OP_MULTU = 3'd0,
        OP_MADDU = 3'd1,
        OP_MSUBU = 3'd2,
        OP_MTHI  = 3'd3,
        OP_MTLO  = 3'd4
    } op_e;
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;
endpackage

// File: rtl/hilo_latency_ctr.sv
// hilo_latency_ctr: loadable down-counter that parks at zero
module hilo_latency_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    assign zero = cnt == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (!zero)
            cnt <= cnt - W'(1);
    end
endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register file with multi-cycle MULTU/MADDU/MSUBU via an external multiplier
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);
    localparam logic [3:0] LOAD_VAL = 4'(LATENCY - 1);

    state_e           state, state_d;
    op_e              op_q;
    logic             zero, accept, is_mul, is_mt, capture;
    logic [ACC_W-1:0] acc, prod, acc_d;

    assign accept  = op_valid && op_ready;
    assign is_mul  = op_code == OP_MULTU || op_code == OP_MADDU || op_code == OP_MSUBU;
    assign is_mt   = op_code == OP_MTHI || op_code == OP_MTLO;
    assign capture = busy && zero;
    assign acc     = {hi, lo};
    assign prod    = {mul_hi, mul_lo};
    assign acc_d   = op_q == OP_MULTU ? prod : op_q == OP_MADDU ? acc + prod : acc - prod;

    hilo_latency_ctr #(.W(4)) u_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept && is_mul),
        .load_val (LOAD_VAL),
        .zero     (zero)
    );

    always_comb begin
        state_d  = state;
        op_ready = state == S_IDLE;
        busy     = state == S_WAIT;
        if (state == S_IDLE && op_valid && is_mul)
            state_d = S_WAIT;
        else if (state == S_WAIT && zero)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op_q  <= OP_MULTU;
            hi    <= '0;
            lo    <= '0;
            mul_a <= '0;
            mul_b <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            done  <= capture || (accept && is_mt);
            if (accept && is_mul) begin
                mul_a <= op_a;
                mul_b <= op_b;
                op_q  <= op_e'(op_code);
            end
            // capture and MTHI/MTLO are mutually exclusive: capture only happens in WAIT
            if (capture)
                {hi, lo} <= acc_d;
            else if (accept && op_code == OP_MTHI)
                hi <= op_a;
            else if (accept && op_code == OP_MTLO)
                lo <= op_a;
        end
    end
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed scoreboard bench for hilo_unit with an attached behavioural multiplier
module tb_hilo_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [2:0]  op_code = 3'd0;
    logic [31:0] op_a = '0, op_b = '0;
    logic [31:0] mul_a, mul_b, mul_hi, mul_lo, hi, lo;
    logic        busy, done;

    int tests = 0, fails = 0, done_cnt = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    assign {mul_hi, mul_lo} = 64'(mul_a) * 64'(mul_b);

    hilo_unit #(.LATENCY(3)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_a(op_a), .op_b(op_b), .mul_a(mul_a), .mul_b(mul_b),
        .mul_hi(mul_hi), .mul_lo(mul_lo), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // monitor: every done pulse must match the oldest expected {hi,lo}
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got hi=0x%0h lo=0x%0h, expected no done", hi, lo);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({hi, lo} !== e) begin
                    fails++;
                    $display("FAIL scoreboard: got 0x%h_%h, expected 0x%h", hi, lo, e);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        op_code = c; op_a = a; op_b = b; op_valid = 1'b1;
        for (int i = 0; i < 50 && !op_ready; i++) @(negedge clk);
        if (!op_ready) check("issue_timeout", 64'(op_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        if (busy) check("idle_timeout", 64'(busy), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int n, d0;
        #2;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_mul", {mul_a, mul_b}, 64'd0);
        check("rst_flags", {61'd0, op_ready, busy, done}, 64'b100);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        exp_q.push_back({32'd0, 32'd200});
        d0 = done_cnt;
        issue(3'd0, 32'd10, 32'd20);
        n = 0;
        while (busy && n < 20) begin n++; @(negedge clk); end
        check("multu_busy_cycles", 64'(n), 64'd3);
        check("multu_done_now", 64'(done), 64'd1);
        @(negedge clk);
        check("multu_done_width", 64'(done_cnt - d0), 64'd1);
        check("multu_done_low", 64'(done), 64'd0);

        exp_q.push_back({32'hFFFF_FFFE, 32'h0000_00C9});
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();

        exp_q.push_back({32'hFFFF_FFFE, 32'd0});
        issue(3'd4, 32'd0, 32'd0);
        exp_q.push_back({32'd0, 32'd0});
        issue(3'd3, 32'd0, 32'd0);
        @(negedge clk);
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFF});
        issue(3'd2, 32'd1, 32'd1);
        wait_idle();

        // MTHI presented during WAIT is held off and then taken in the done cycle
        exp_q.push_back({32'd0, 32'd6});
        exp_q.push_back({32'h1234_5678, 32'd6});
        issue(3'd0, 32'd2, 32'd3);
        op_code = 3'd3; op_a = 32'h1234_5678; op_b = '0; op_valid = 1'b1;
        check("wait_ready_low", 64'(op_ready), 64'd0);
        for (int i = 0; i < 50 && !op_ready; i++) @(negedge clk);
        check("mthi_in_done_cycle", 64'(done), 64'd1);
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        check("mthi_mul_held", {mul_a, mul_b}, {32'd2, 32'd3});
        @(negedge clk);

        // reset during WAIT aborts the multiply
        d0 = done_cnt;
        issue(3'd0, 32'd3, 32'd15);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_flags", {62'd0, op_ready, busy}, 64'b10);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        exp_q.push_back({32'd0, 32'd112});
        issue(3'd0, 32'd16, 32'd7);
        wait_idle();
        check("mul_hold", {mul_a, mul_b}, {32'd16, 32'd7});

        // reserved op code is consumed but has no effect
        d0 = done_cnt;
        issue(3'd6, 32'hDEAD_BEEF, 32'h1);
        repeat (4) @(negedge clk);
        check("rsvd_hilo", {hi, lo}, {32'd0, 32'd112});
        check("rsvd_no_done", 64'(done_cnt - d0), 64'd0);
        check("rsvd_idle", {62'd0, op_ready, busy}, 64'b10);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have parameter LATENCY, default 3, giving the multiplier settle cycles (legal 1..15).
REQ-002 SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port op_valid, input, 1 bit, which marks op_code, op_a and op_b as valid.
REQ-005 SHALL have port op_ready, output, 1 bit; the block can accept an op.
REQ-006 SHALL have port op_code, input, 3 bits: 0 MULTU, 1 MADDU, 2 MSUBU, 3 MTHI, 4 MTLO, 5-7 reserved.
REQ-007 SHALL have ports op_a and op_b, input, 32 bits each, the unsigned operands.
REQ-008 SHALL have ports mul_a and mul_b, output, 32 bits each, the registered operands driven to the combinational 32x32 unsigned multiplier.
REQ-009 SHALL have ports mul_hi and mul_lo, input, 32 bits each, the product returned from that multiplier.
REQ-010 SHALL have ports hi and lo, output, 32 bits each, the architectural HI and LO registers.
REQ-011 SHALL have port busy, output, 1 bit, which is high while a multiply is in flight.
REQ-012 SHALL have port done, output, 1 bit, a one-cycle pulse emitted when hi and lo have been updated.

Function
REQ-013 SHALL implement a two-state FSM:
- IDLE: op_ready=1, busy=0.
- WAIT: op_ready=0, busy=1.
REQ-014 SHALL accept an op on a rising edge where op_valid and op_ready are both high.
REQ-015 SHALL handle MTHI or MTLO accepted in IDLE as follows:
- At that edge, write op_a into hi or lo respectively.
- Remain in IDLE.
- Assert done for the following cycle.
REQ-016 SHALL handle MULTU, MADDU or MSUBU accepted in IDLE as follows:
- Latch op_a and op_b into mul_a and mul_b.
- Load a down-counter with LATENCY-1.
- Enter WAIT.
REQ-017 SHALL, in WAIT, decrement the counter each edge; on the edge where the counter is 0, do all of the following:
- Update {hi,lo}.
- Return to IDLE.
- Assert done for the following cycle.
REQ-018 SHALL have the update rule:
- MULTU: {hi,lo} = {mul_hi,mul_lo}.
- MADDU: {hi,lo} = {hi,lo} + {mul_hi,mul_lo} modulo 2^64.
- MSUBU: {hi,lo} = {hi,lo} - {mul_hi,mul_lo} modulo 2^64.
- Carry and borrow are discarded.
REQ-019 SHALL have multiply latency exactly LATENCY edges: for an op accepted at edge k, hi and lo are new after edge k+LATENCY, and done is high in the cycle following that edge.
REQ-020 SHALL hold mul_a and mul_b stable from acceptance until the capture edge, and hold them afterwards until the next multiply is accepted.
REQ-021 SHALL accept reserved op codes 5-7 in IDLE but ignore them: no state change and no done pulse.
REQ-022 SHALL ignore op_valid while in WAIT; the op is not consumed, and the upstream stage must keep it stable until op_ready is high.
REQ-023 SHALL allow a new op to be accepted in the same cycle that done is high (back-to-back operation).
REQ-024 SHALL keep hi and lo unchanged except on the writes defined in REQ-015 and REQ-017.

Reset
REQ-025 SHALL, on rst_n low, immediately and asynchronously force:
- state=IDLE
- hi=0, lo=0
- mul_a=0, mul_b=0
- counter=0
- done=0, busy=0
- op_ready=1 (derived from state IDLE)
REQ-026 SHALL, when reset is asserted during WAIT, abort the multiply with no hi/lo update and no done pulse.
REQ-027 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Structure
REQ-028 SHALL place the op_code encodings, the state enum, and the 64-bit accumulator width constant in a shared package, hilo_pkg.
REQ-029 SHALL NOT instantiate the multiplier internally; the multiplier is connected externally via mul_a, mul_b, mul_hi and mul_lo.
REQ-030 SHALL contain exactly one natural sub-module, hilo_latency_ctr (the WAIT down-counter), with a load/zero interface.

Verification
REQ-031 SHALL pass this scenario (LATENCY=3, bench multiplier attached): MULTU 10,20 accepted at edge 0 -> hi=0, lo=200 after edge 3; done high for exactly one cycle; busy high for 3 cycles.
REQ-032 SHALL pass this scenario: starting from hi=0, lo=200, MADDU 0xFFFFFFFF,0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x000000C9.
REQ-033 SHALL pass this scenario: starting from hi=0, lo=0, MSUBU 1,1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF (wrap-around).
REQ-034 SHALL pass this scenario: MTHI 0x12345678 presented while in WAIT -> op_ready low and op not taken; the op is accepted in the done cycle; hi=0x12345678 one edge later.
REQ-035 SHALL pass this scenario: MULTU 3,15, then rst_n pulsed low after edge 1 -> hi=lo=0, no done pulse, op_ready=1; a following MULTU 16,7 gives lo=112.
REQ-036 SHALL pass this scenario: op_code 6 with op_valid high for one cycle -> no change to hi or lo, no done pulse, and the FSM remains in IDLE.
